// File: rtl/cpu_control.sv
// ============================================================================
// Module      : cpu_control
// Description : Instruction capture and T-state sequencer for the 16-bit
//               bus-based processor. Decodes register-file, bus-source,
//               A/G enables and ALU operation from the current state and IR.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_control #(
  parameter int WORD = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [WORD-1:0] din,
  output logic [8:0]      ir_q,
  output logic [7:0]      r_in,
  output logic [7:0]      r_out,
  output logic            din_out,
  output logic            g_out,
  output logic            a_in,
  output logic            g_in,
  output logic [1:0]      alu_op,
  output logic            done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t     state;
  logic [8:0] ir;
  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;
  logic       is_arith;
  logic       unused_din;

  assign opcode   = ir[8:6];
  assign rx       = ir[5:3];
  assign ry       = ir[2:0];
  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign ir_q     = ir;

  // Upper data bits only matter to the datapath (mvi immediate), not here.
  assign unused_din = ^din[WORD-1:9];

  // Sequencer: capture the instruction in T0, then walk the T-states.
  // Two-step instructions return to T0 from T1; add/sub continue to T3.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= T0;
      ir    <= 9'd0;
    end else begin
      case (state)
        T0: begin
          if (run) begin
            ir    <= din[8:0];
            state <= T1;
          end
        end
        T1:      state <= is_arith ? T2 : T0;
        T2:      state <= is_arith ? T3 : T0;
        default: state <= T0;
      endcase
    end
  end

  // Control decode from state and IR; reset forces every control low.
  always_comb begin
    r_in    = 8'd0;
    r_out   = 8'd0;
    din_out = 1'b0;
    g_out   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    alu_op  = 2'b00;
    done    = 1'b0;
    if (!reset) begin
      case (state)
        T1: begin
          case (opcode)
            OP_MV: begin
              r_out = 8'd1 << ry;
              r_in  = 8'd1 << rx;
              done  = 1'b1;
            end
            OP_MVI: begin
              din_out = 1'b1;
              r_in    = 8'd1 << rx;
              done    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              r_out = 8'd1 << rx;
              a_in  = 1'b1;
            end
            default: done = 1'b1;
          endcase
        end
        T2: begin
          if (is_arith) begin
            r_out  = 8'd1 << ry;
            g_in   = 1'b1;
            alu_op = (opcode == OP_ADD) ? 2'b01 : 2'b10;
          end
        end
        T3: begin
          if (is_arith) begin
            g_out = 1'b1;
            r_in  = 8'd1 << rx;
            done  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_control.sv
// ============================================================================
// Module      : tb_cpu_control
// Description : Self-checking bench for cpu_control. An instruction-level
//               model expands each accepted instruction into its list of
//               expected control vectors; a compare process checks the DUT
//               each cycle, and directed steps pin hand-computed values.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_control;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic [8:0]  ir_q;
  logic [7:0]  r_in;
  logic [7:0]  r_out;
  logic        din_out;
  logic        g_out;
  logic        a_in;
  logic        g_in;
  logic [1:0]  alu_op;
  logic        done;

  cpu_control #(.WORD(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .din     (din),
    .ir_q    (ir_q),
    .r_in    (r_in),
    .r_out   (r_out),
    .din_out (din_out),
    .g_out   (g_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .alu_op  (alu_op),
    .done    (done)
  );

  typedef struct packed {
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       din_out;
    logic       g_out;
    logic       a_in;
    logic       g_in;
    logic [1:0] alu_op;
    logic       done;
  } ctl_t;

  int   errors = 0;
  int   checks = 0;
  ctl_t exp_q[$];
  logic [8:0] m_ir;
  bit   started = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Expand one instruction into the controls it must produce, one entry per
  // cycle after the accepting edge.
  task automatic expand(input logic [8:0] ins);
    ctl_t v;
    logic [2:0] op, rx, ry;
    op = ins[8:6]; rx = ins[5:3]; ry = ins[2:0];
    v = '0;
    if (op == 3'd0) begin
      v.r_out = 8'd1 << ry; v.r_in = 8'd1 << rx; v.done = 1'b1;
      exp_q.push_back(v);
    end else if (op == 3'd1) begin
      v.din_out = 1'b1; v.r_in = 8'd1 << rx; v.done = 1'b1;
      exp_q.push_back(v);
    end else if (op == 3'd2 || op == 3'd3) begin
      v.r_out = 8'd1 << rx; v.a_in = 1'b1;
      exp_q.push_back(v);
      v = '0;
      v.r_out = 8'd1 << ry; v.g_in = 1'b1; v.alu_op = (op == 3'd2) ? 2'd1 : 2'd2;
      exp_q.push_back(v);
      v = '0;
      v.g_out = 1'b1; v.r_in = 8'd1 << rx; v.done = 1'b1;
      exp_q.push_back(v);
    end else begin
      v.done = 1'b1;
      exp_q.push_back(v);
    end
  endtask

  // Model advance at each active edge.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_ir = 9'd0;
      started = 1;
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (run) begin
      m_ir = din[8:0];
      expand(din[8:0]);
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    ctl_t act, req;
    if (started) begin
      act = '{r_in, r_out, din_out, g_out, a_in, g_in, alu_op, done};
      req = '0;
      if (!reset && exp_q.size() != 0) req = exp_q[0];
      chk("ctl_vector", 32'(act), 32'(req));
      chk("ir_q", 32'(ir_q), 32'(m_ir));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; din = 16'h0000;
    // Reset two cycles with run high.
    step();
    step();
    #1;
    chk("reset_ir_q", 32'(ir_q), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_r_in", 32'(r_in), 32'h0);
    reset = 1'b0; run = 1'b0;
    repeat (5) step();
    chk("idle_done", 32'(done), 32'h0);

    // mvi R3, 0x00A5
    din = 16'h0058; run = 1'b1;
    step();
    din = 16'h00A5; run = 1'b0;
    #1;
    chk("mvi_din_out", 32'(din_out), 32'h1);
    chk("mvi_r_in", 32'(r_in), 32'h08);
    chk("mvi_done", 32'(done), 32'h1);
    step();
    chk("mvi_after_r_in", 32'(r_in), 32'h0);
    chk("mvi_after_done", 32'(done), 32'h0);

    // add R2, R5
    din = 16'h0095; run = 1'b1;
    step();
    run = 1'b0;
    chk("add_t1_r_out", 32'(r_out), 32'h04);
    chk("add_t1_a_in", 32'(a_in), 32'h1);
    step();
    chk("add_t2_r_out", 32'(r_out), 32'h20);
    chk("add_t2_g_in", 32'(g_in), 32'h1);
    chk("add_t2_alu_op", 32'(alu_op), 32'h1);
    step();
    chk("add_t3_g_out", 32'(g_out), 32'h1);
    chk("add_t3_r_in", 32'(r_in), 32'h04);
    chk("add_t3_done", 32'(done), 32'h1);
    step();
    chk("add_t0_done", 32'(done), 32'h0);

    // sub R7, R7 then mv R0, R7 with run held high.
    din = 16'h00FF; run = 1'b1;
    step();
    chk("sub_t1_r_out", 32'(r_out), 32'h80);
    din = 16'h0007;
    step();
    chk("sub_t2_alu_op", 32'(alu_op), 32'h2);
    step();
    chk("sub_t3_done", 32'(done), 32'h1);
    chk("sub_t3_r_in", 32'(r_in), 32'h80);
    step();
    chk("sub_t0_done", 32'(done), 32'h0);
    step();
    chk("mv_r_out", 32'(r_out), 32'h80);
    chk("mv_r_in", 32'(r_in), 32'h01);
    chk("mv_done", 32'(done), 32'h1);
    run = 1'b0;
    step();

    // Reset during T2 of an add aborts it.
    din = 16'h0095; run = 1'b1;
    step();
    run = 1'b0;
    step();
    chk("abort_pre_g_in", 32'(g_in), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_forced_g_in", 32'(g_in), 32'h0);
    step();
    reset = 1'b0;
    #1;
    chk("abort_alu_op", 32'(alu_op), 32'h0);
    chk("abort_g_in", 32'(g_in), 32'h0);
    chk("abort_ir_q", 32'(ir_q), 32'h0);
    step();
    chk("abort_no_done", 32'(done), 32'h0);
    chk("abort_no_r_in", 32'(r_in), 32'h0);

    // NOP opcode 110.
    din = 16'h01AB; run = 1'b1;
    step();
    run = 1'b0;
    chk("nop_done", 32'(done), 32'h1);
    chk("nop_r_in", 32'(r_in), 32'h0);
    chk("nop_a_in", 32'(a_in), 32'h0);
    chk("nop_ir_q", 32'(ir_q), 32'h1AB);
    step();
    chk("nop_after_done", 32'(done), 32'h0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
